// File: rtl/multi_counter.sv
// multi_counter: bus-mapped timer, NumCounters channels with prescaler, compare/match, auto-reload and IRQ.
// Latency: every accepted request returns rvalid with registered rdata/err exactly one cycle later.
// Backpressure: none, a request is accepted every cycle. Define MULTI_COUNTER_SNAPSHOT_EN for VALUE_HI shadows.
module multi_counter #(
    parameter int unsigned             DataWidth    = 32,
    parameter int unsigned             AddressWidth = 32,
    parameter int unsigned             NumCounters  = 4,
    parameter int unsigned             CounterWidth = 64,
    parameter logic [AddressWidth-1:0] BaseAddr     = 32'h40000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     counter_req_i,
    input  logic [AddressWidth-1:0]  counter_addr_i,
    input  logic                     counter_we_i,
    input  logic [DataWidth/8-1:0]   counter_be_i,
    input  logic [DataWidth-1:0]     counter_wdata_i,
    output logic                     counter_rvalid_o,
    output logic [DataWidth-1:0]     counter_rdata_o,
    output logic                     counter_err_o,
    output logic [NumCounters-1:0]   irq_o
);

    // Word index of each register inside a channel's 0x20-byte window.
    localparam logic [2:0] OffCtrl   = 3'd0;
    localparam logic [2:0] OffPresc  = 3'd1;
    localparam logic [2:0] OffValLo  = 3'd2;
    localparam logic [2:0] OffValHi  = 3'd3;
    localparam logic [2:0] OffCmpLo  = 3'd4;
    localparam logic [2:0] OffCmpHi  = 3'd5;
    localparam logic [2:0] OffStatus = 3'd6;
    localparam logic [2:0] OffRsvd   = 3'd7;

    // Bytes covered by all channels; anything past this is a decode error.
    localparam logic [AddressWidth-1:0] Span = AddressWidth'(NumCounters * 32);

    // Counter state is held 64 bits wide; bits at or above CounterWidth are forced to 0.
    localparam logic [63:0] CntMask = (CounterWidth >= 64) ? {64{1'b1}}
                                                           : ((64'd1 << CounterWidth) - 64'd1);

    // Byte-enable merge of a 32-bit write into an existing word.
    function automatic logic [31:0] merge32(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Per-channel architectural state.
    logic [2:0]             ctrl_q     [NumCounters];
    logic [2:0]             ctrl_d     [NumCounters];
    logic [15:0]            prescale_q [NumCounters];
    logic [15:0]            prescale_d [NumCounters];
    logic [15:0]            pre_q      [NumCounters];
    logic [15:0]            pre_d      [NumCounters];
    logic [63:0]            value_q    [NumCounters];
    logic [63:0]            value_d    [NumCounters];
    logic [63:0]            cmp_q      [NumCounters];
    logic [63:0]            cmp_d      [NumCounters];
    logic [NumCounters-1:0] match_q;
    logic [NumCounters-1:0] match_d;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    logic [31:0]            shadow_q   [NumCounters];
    logic [31:0]            shadow_d   [NumCounters];
`endif

    // Bus response registers.
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Decode results.
    logic [AddressWidth-1:0] rel_addr;
    logic                    in_range;
    logic [2:0]              ch_idx;
    logic [2:0]              word_off;
    logic                    addr_err;
    logic                    wr_ok;
    logic                    rd_ok;
    logic [31:0]             wdata;
    logic [3:0]              wbe;
    logic [31:0]             rd_word;

    assign wdata = counter_wdata_i;
    assign wbe   = counter_be_i;

    // Address decode: channel, register word and error classification.
    always_comb begin
        rel_addr = counter_addr_i - BaseAddr;
        in_range = (counter_addr_i >= BaseAddr) && (rel_addr < Span);
        ch_idx   = rel_addr[7:5];
        word_off = rel_addr[4:2];
        addr_err = !in_range || (counter_addr_i[1:0] != 2'b00) || (word_off == OffRsvd);
        wr_ok    = counter_req_i && counter_we_i && !addr_err;
        rd_ok    = counter_req_i && !counter_we_i && !addr_err;
    end

    // Channel next-state: prescaler, counting, compare and bus writes (bus writes to VALUE win over ticks).
    always_comb begin
        logic        sel;
        logic        tick;
        logic        hit;
        logic        val_wr;
        logic [63:0] val_inc;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pre_d      = pre_q;
        value_d    = value_q;
        cmp_d      = cmp_q;
        match_d    = match_q;
        for (int i = 0; i < NumCounters; i++) begin
            sel     = wr_ok && (ch_idx == 3'(i));
            tick    = ctrl_q[i][0] && (pre_q[i] == prescale_q[i]);
            val_wr  = sel && ((word_off == OffValLo) || (word_off == OffValHi));
            hit     = tick && !val_wr && (value_q[i] == cmp_q[i]);
            val_inc = (value_q[i] + 64'd1) & CntMask;

            // Prescaler advances only while enabled; a tick restarts it.
            if (ctrl_q[i][0]) begin
                pre_d[i] = tick ? 16'd0 : pre_q[i] + 16'd1;
            end

            // Counting with compare, auto-reload and natural wrap.
            if (tick) begin
                if (value_q[i] == cmp_q[i]) begin
                    value_d[i] = ctrl_q[i][1] ? 64'd0 : val_inc;
                end else begin
                    value_d[i] = val_inc;
                end
            end

            // Register writes from the bus.
            if (sel) begin
                case (word_off)
                    OffCtrl: begin
                        if (wbe[0]) begin
                            ctrl_d[i] = wdata[2:0];
                        end
                    end
                    OffPresc: begin
                        prescale_d[i] = merge32({16'd0, prescale_q[i]}, wdata, wbe) & 32'h0000_FFFF;
                        pre_d[i]      = 16'd0;
                    end
                    OffValLo: value_d[i] = {value_q[i][63:32],
                                            merge32(value_q[i][31:0], wdata, wbe)} & CntMask;
                    OffValHi: value_d[i] = {merge32(value_q[i][63:32], wdata, wbe),
                                            value_q[i][31:0]} & CntMask;
                    OffCmpLo: cmp_d[i]   = {cmp_q[i][63:32],
                                            merge32(cmp_q[i][31:0], wdata, wbe)} & CntMask;
                    OffCmpHi: cmp_d[i]   = {merge32(cmp_q[i][63:32], wdata, wbe),
                                            cmp_q[i][31:0]} & CntMask;
                    OffStatus: begin
                        if (wbe[0] && wdata[0]) begin
                            match_d[i] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (hit) begin
                match_d[i] = 1'b1;
            end
        end
    end

    // Read mux for the addressed channel; a VALUE_LO read also captures the upper half when snapshots exist.
    always_comb begin
        rd_word = 32'd0;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        shadow_d = shadow_q;
`endif
        for (int i = 0; i < NumCounters; i++) begin
            if (ch_idx == 3'(i)) begin
                case (word_off)
                    OffCtrl:   rd_word = {29'd0, ctrl_q[i]};
                    OffPresc:  rd_word = {16'd0, prescale_q[i]};
                    OffValLo:  rd_word = value_q[i][31:0];
`ifdef MULTI_COUNTER_SNAPSHOT_EN
                    OffValHi:  rd_word = shadow_q[i];
`else
                    OffValHi:  rd_word = value_q[i][63:32];
`endif
                    OffCmpLo:  rd_word = cmp_q[i][31:0];
                    OffCmpHi:  rd_word = cmp_q[i][63:32];
                    OffStatus: rd_word = {31'd0, match_q[i]};
                    default:   rd_word = 32'd0;
                endcase
`ifdef MULTI_COUNTER_SNAPSHOT_EN
                if (rd_ok && (word_off == OffValLo)) begin
                    shadow_d[i] = value_q[i][63:32];
                end
`endif
            end
        end
    end

    // Response next-state: one-cycle rvalid, zero data on writes and errors, hold data when idle.
    always_comb begin
        rvalid_d = counter_req_i;
        err_d    = counter_req_i && addr_err;
        rdata_d  = rdata_q;
        if (counter_req_i) begin
            rdata_d = rd_ok ? rd_word : 32'd0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumCounters; i++) begin
                ctrl_q[i]     <= 3'd0;
                prescale_q[i] <= 16'd0;
                pre_q[i]      <= 16'd0;
                value_q[i]    <= 64'd0;
                cmp_q[i]      <= 64'd0;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
                shadow_q[i]   <= 32'd0;
`endif
            end
            match_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            for (int i = 0; i < NumCounters; i++) begin
                ctrl_q[i]     <= ctrl_d[i];
                prescale_q[i] <= prescale_d[i];
                pre_q[i]      <= pre_d[i];
                value_q[i]    <= value_d[i];
                cmp_q[i]      <= cmp_d[i];
`ifdef MULTI_COUNTER_SNAPSHOT_EN
                shadow_q[i]   <= shadow_d[i];
`endif
            end
            match_q  <= match_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Interrupts are a direct AND of flopped MATCH and IRQ_EN.
    always_comb begin
        irq_o = '0;
        for (int i = 0; i < NumCounters; i++) begin
            irq_o[i] = match_q[i] & ctrl_q[i][2];
        end
    end

    assign counter_rvalid_o = rvalid_q;
    assign counter_err_o    = err_q;
    assign counter_rdata_o  = rdata_q;

endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed register-level bench for multi_counter with hand-computed expectations.
// Latency: each bus call drives at a negedge and samples the response at the following negedge.
// Backpressure: none; transactions are issued back-to-back, idle cycles are explicit.
module tb_multi_counter;

    localparam logic [31:0] B = 32'h40000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  irq;

    logic        rsp_vld;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    multi_counter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .counter_req_i    (req),
        .counter_addr_i   (addr),
        .counter_we_i     (we),
        .counter_be_i     (be),
        .counter_wdata_i  (wdat),
        .counter_rvalid_o (rvalid),
        .counter_rdata_o  (rdata),
        .counter_err_o    (err),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the response captured.
    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        req  = 1'b1;
        addr = a;
        we   = w;
        be   = b;
        wdat = d;
        @(negedge clk);
        req     = 1'b0;
        we      = 1'b0;
        rsp_vld = rvalid;
        rsp_dat = rdata;
        rsp_err = err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(a, 1'b1, 4'hF, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus(a, 1'b0, 4'hF, 32'd0);
        check({tag, ".vld"}, {31'd0, rsp_vld}, 32'd1);
        check({tag, ".err"}, {31'd0, rsp_err}, 32'd0);
        check(tag, rsp_dat, exp);
    endtask

    task automatic err_chk(input string tag, input logic [31:0] a, input logic w);
        bus(a, w, 4'hF, 32'h0000_00AA);
        check({tag, ".vld"}, {31'd0, rsp_vld}, 32'd1);
        check({tag, ".err"}, {31'd0, rsp_err}, 32'd1);
        check({tag, ".dat"}, rsp_dat, 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        addr = '0;
        we   = 1'b0;
        be   = 4'h0;
        wdat = '0;
        repeat (3) @(negedge clk);
        check("rst.rvalid", {31'd0, rvalid}, 32'd0);
        check("rst.err",    {31'd0, err},    32'd0);
        check("rst.rdata",  rdata,           32'd0);
        check("rst.irq",    {28'd0, irq},    32'd0);
        rst = 1'b0;

        // Read after reset.
        rd_chk("t1.val_lo", B + 32'h08, 32'd0);
        check("t1.irq", {28'd0, irq}, 32'd0);
        @(negedge clk);
        check("t1.idle_rvalid", {31'd0, rvalid}, 32'd0);

        // Ch0: prescale 3, compare 5, auto-reload + irq. Ticks every 4 cycles, match on the 6th tick.
        wr(B + 32'h04, 32'd3);
        wr(B + 32'h10, 32'd5);
        wr(B + 32'h00, 32'd7);
        repeat (23) @(negedge clk);
        check("t2.irq_early", {28'd0, irq}, 32'd0);
        @(negedge clk);
        check("t2.irq_match", {28'd0, irq}, 32'd1);
        rd_chk("t2.status", B + 32'h18, 32'd1);
        rd_chk("t2.reload", B + 32'h08, 32'd0);
        wr(B + 32'h18, 32'd1);
        check("t2.irq_clr", {28'd0, irq}, 32'd0);
        rd_chk("t2.status_clr", B + 32'h18, 32'd0);
        wr(B + 32'h00, 32'hFFFF_FFF8);
        rd_chk("t2.ctrl_rsvd", B + 32'h00, 32'd0);

        // Ch1: 64-bit wrap from all-ones with prescale 0.
        wr(B + 32'h28, 32'hFFFF_FFFF);
        wr(B + 32'h2C, 32'hFFFF_FFFF);
        wr(B + 32'h24, 32'd0);
        wr(B + 32'h20, 32'd1);
        @(negedge clk);
        rd_chk("t3.lo_wrap", B + 32'h28, 32'd0);
        rd_chk("t3.hi_wrap", B + 32'h2C, 32'd0);
        rd_chk("t3.lo_inc",  B + 32'h28, 32'd2);
        wr(B + 32'h20, 32'd0);
        rd_chk("t3.cmp0_match", B + 32'h38, 32'd1);

        // Error responses and no side effects.
        rd_chk("t4.cmp_pre", B + 32'h10, 32'd5);
        err_chk("t4.past_end", B + 32'h80, 1'b0);
        err_chk("t4.rsvd",     B + 32'h1C, 1'b0);
        err_chk("t4.misalign", B + 32'h02, 1'b0);
        err_chk("t4.below",    B - 32'h04, 1'b0);
        err_chk("t4.bad_wr",   B + 32'h12, 1'b1);
        rd_chk("t4.cmp_post", B + 32'h10, 32'd5);
        wr(B + 32'h04, 32'hFFFF_FFFF);
        rd_chk("t4.presc_width", B + 32'h04, 32'h0000_FFFF);

        // Ch2: byte-enabled VALUE_LO write in a tick cycle wins over the increment.
        wr(B + 32'h44, 32'd0);
        wr(B + 32'h48, 32'h1234_5678);
        wr(B + 32'h40, 32'd1);
        bus(B + 32'h48, 1'b1, 4'b0001, 32'h0000_0100);
        rd_chk("t5.val_wr",  B + 32'h48, 32'h1234_5600);
        rd_chk("t5.val_inc", B + 32'h48, 32'h1234_5601);
        wr(B + 32'h40, 32'd0);

        // Ch3: W1C lands on the same cycle as a new match; set wins.
        wr(B + 32'h70, 32'd3);
        wr(B + 32'h64, 32'd0);
        wr(B + 32'h68, 32'd0);
        wr(B + 32'h60, 32'd5);
        repeat (3) @(negedge clk);
        wr(B + 32'h78, 32'd1);
        check("t5.irq_set_wins", {28'd0, irq}, 32'd8);
        rd_chk("t5.status_set", B + 32'h78, 32'd1);
        rd_chk("t5.no_reload",  B + 32'h68, 32'd5);
        wr(B + 32'h78, 32'd1);
        rd_chk("t5.status_clr", B + 32'h78, 32'd0);
        check("t5.irq_clr", {28'd0, irq}, 32'd0);
        wr(B + 32'h60, 32'd0);

        // Ch1: LO read followed later by HI read across a carry into the upper half.
        wr(B + 32'h2C, 32'd0);
        wr(B + 32'h28, 32'hFFFF_FFFE);
        wr(B + 32'h24, 32'd0);
        wr(B + 32'h20, 32'd1);
        rd_chk("t6.lo", B + 32'h28, 32'hFFFF_FFFE);
        repeat (5) @(negedge clk);
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        rd_chk("t6.hi_snap", B + 32'h2C, 32'd0);
`else
        rd_chk("t6.hi_live", B + 32'h2C, 32'd1);
`endif
        rd_chk("t6.lo_after", B + 32'h28, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
Bus-mapped timer peripheral, successor to the single free-running 32-bit counter.
- Provides NumCounters independent channels, each CounterWidth bits (up to 64).
- Each channel has a programmable prescaler, a compare register with match flag and auto-reload, and an interrupt line.
- Sits on the core data bus at BaseAddr and is read and written by firmware like any other slave.

Parameters:
- DataWidth, 32, bus data width; must be 32.
- AddressWidth, 32, bus address width.
- NumCounters, 4, channel count, 1..8.
- CounterWidth, 64, counter/compare width, 1..64.
- BaseAddr, 32'h40000, base address; channel i at BaseAddr + i*0x20.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- counter_req_i  in  1  bus request
- counter_addr_i  in  AddressWidth  byte address
- counter_we_i  in  1  write enable
- counter_be_i  in  DataWidth/8  byte enables
- counter_wdata_i  in  DataWidth  write data
- counter_rvalid_o  out  1  response valid
- counter_rdata_o  out  DataWidth  read data
- counter_err_o  out  1  error response
- irq_o  out  NumCounters  per-channel interrupt, level

Behaviour:
- Reset (rst_i high at posedge): all registers, prescaler counts and shadows go to 0; rvalid/err/rdata/irq_o are 0 the following cycle.
- Channel register offsets (from channel base):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [15:0].
  - 0x08 VALUE_LO, 0x0C VALUE_HI.
  - 0x10 CMP_LO, 0x14 CMP_HI.
  - 0x18 STATUS: [0] MATCH, write-1-to-clear.
- Width rules: bits at or above CounterWidth read 0 and ignore writes. If CounterWidth <= 32, the HI registers read 0.
- Bus response: every accepted req produces rvalid exactly 1 cycle later, for reads and writes alike. No back-pressure; req is accepted every cycle.
- Error response: err=1 with rvalid when any of the following holds; writes are then ignored and rdata=0:
  - channel index >= NumCounters
  - offset is 0x1C
  - addr[1:0] != 0
  - address outside BaseAddr .. BaseAddr + NumCounters*0x20 - 1
- Writes honour counter_be_i per byte. Read data is registered; rdata holds its last value when rvalid=0.
- Prescaler: per-channel pre_q counts while EN=1.
  - tick when pre_q == PRESCALE, then pre_q <= 0; otherwise pre_q increments.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds both pre_q and value.
- On tick:
  - if value == CMP: MATCH <= 1; value <= 0 if AUTO_RELOAD, else value+1.
  - else value <= value+1, wrapping from 2^CounterWidth-1 to 0.
- Collisions:
  - A bus write to VALUE_LO/HI in a tick cycle wins: the written bytes are stored and no increment or match occurs that cycle.
  - A bus write to CMP in a tick cycle: the compare uses the old CMP.
  - A STATUS W1C in the same cycle as a new match: set wins, MATCH=1.
- Writing PRESCALE resets pre_q to 0.
- irq_o[i] = MATCH[i] & IRQ_EN[i], driven from flops with no extra latency.

Optional Feature:
Macro: MULTI_COUNTER_SNAPSHOT_EN.
- Defined: reading VALUE_LO latches the channel's value[63:32] into a per-channel shadow in the same cycle. VALUE_HI reads return that shadow, giving an atomic 64-bit read as LO then HI. Shadows reset to 0.
- Undefined: VALUE_HI returns the live upper bits and no shadow flops exist.

Test Plan:
1. Reset, then read BaseAddr+0x08 -> rvalid 1 cycle after req, rdata=0, err=0; irq_o=0.
2. Ch0: PRESCALE=3, CMP_LO=5, CTRL=0x7. Wait 24 cycles after the enable write -> MATCH=1, irq_o[0]=1, VALUE_LO=0 or 1. Write 1 to STATUS -> irq_o[0] drops the next cycle.
3. Ch1: AUTO_RELOAD=0, VALUE_LO/HI = 0xFFFFFFFF/0xFFFFFFFF, PRESCALE=0, EN=1 -> value reads 0 then increments (64-bit wrap).
4. Read BaseAddr + NumCounters*0x20, then BaseAddr+0x1C, then BaseAddr+0x02 -> err=1 with rvalid for each, rdata=0, no register changes.
5. Write VALUE_LO=0x100 with be=4'b0001 in a tick cycle -> VALUE_LO low byte = 0x00, upper bytes unchanged, no increment that cycle. Separately, a STATUS W1C coincident with a match -> MATCH stays 1.
6. With the snapshot macro: VALUE_HI=0, VALUE_LO=0xFFFFFFFE, PRESCALE=0. Read LO (0xFFFFFFFE..), wait 5 cycles, read HI -> 0. Without the macro -> 1.
